frame_buffer_reader: RTL and testbench

- Streams a contiguous region of the frame buffer (color or Z) out of memory over an Avalon-MM burst-read master and hands 64-bit words to a consumer through a valid/ready interface.
- Read-side counterpart of the write queue that feeds frame-buffer writes. Used for display scan-out and Z prefetch.
- Uses a credit scheme so the internal FIFO can never overflow, whatever the memory read latency.

---
 rtl/frame_buffer_reader_pkg.sv | 34 +++
 rtl/frame_buffer_reader_if.sv | 40 ++++
 rtl/frame_buffer_reader_read_data_fifo.sv | 68 ++++++
 rtl/frame_buffer_reader.sv | 179 +++++++++++++++++
 tb/tb_frame_buffer_reader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_buffer_reader_pkg.sv
// Frame-buffer memory constants shared by the read path and the write queue:
// bus widths, error codes and the reader state encoding.
package frame_buffer_reader_pkg;

    localparam int unsigned ADDR_WIDTH           = 29;
    localparam int unsigned DATA_WIDTH           = 64;
    localparam int unsigned BURST_COUNT_WIDTH    = 8;
    localparam int unsigned WORD_COUNT_WIDTH     = 24;
    localparam int unsigned DEFAULT_BURST_LENGTH = 16;

    localparam logic [7:0] ERR_NONE       = 8'h00;
    localparam logic [7:0] ERR_STRAY_DATA = 8'h80;
    localparam logic [7:0] ERR_OVERFLOW   = 8'h40;
    localparam logic [7:0] ERR_START_BUSY = 8'h20;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAccept,
        StDrain
    } reader_state_e;

    // Length of the next burst: the full burst, or whatever is left of the frame.
    function automatic logic [BURST_COUNT_WIDTH-1:0] burst_len(
        input logic [WORD_COUNT_WIDTH-1:0] remaining,
        input int unsigned                 max_len
    );
        if (remaining >= WORD_COUNT_WIDTH'(max_len)) begin
            return BURST_COUNT_WIDTH'(max_len);
        end
        return remaining[BURST_COUNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/frame_buffer_reader_if.sv
// Avalon-MM burst-read master bus plus the valid/ready pixel stream of the reader.
interface frame_buffer_reader_if;
    import frame_buffer_reader_pkg::*;

    logic [ADDR_WIDTH-1:0]        read_address;
    logic [BURST_COUNT_WIDTH-1:0] read_burstcount;
    logic                         read_read;
    logic                         read_waitrequest;
    logic [DATA_WIDTH-1:0]        read_readdata;
    logic                         read_readdatavalid;

    logic [DATA_WIDTH-1:0]        pixel_data;
    logic                         pixel_valid;
    logic                         pixel_ready;

    modport master (
        output read_address,
        output read_burstcount,
        output read_read,
        input  read_waitrequest,
        input  read_readdata,
        input  read_readdatavalid,
        output pixel_data,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  read_address,
        input  read_burstcount,
        input  read_read,
        output read_waitrequest,
        output read_readdata,
        output read_readdatavalid,
        input  pixel_data,
        input  pixel_valid,
        output pixel_ready
    );

endinterface

// File: rtl/frame_buffer_reader_read_data_fifo.sv
// Show-ahead single-clock FIFO with scfifo-style status: usedw wraps to 0 when full,
// so {full, usedw} is the exact occupancy.
module read_data_fifo
    import frame_buffer_reader_pkg::*;
#(
    parameter int unsigned WIDTH           = DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned FIFO_DEPTH_LOG2 = 6
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wrreq,
    input  logic [WIDTH-1:0]           data,
    input  logic                       rdreq,
    output logic [WIDTH-1:0]           q,
    output logic                       empty,
    output logic                       full,
    output logic [FIFO_DEPTH_LOG2-1:0] usedw
);

    logic [WIDTH-1:0]           mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q;
    logic [FIFO_DEPTH_LOG2:0]   count_d;
    logic                       do_write;
    logic                       do_read;

    assign empty    = (count_q == '0);
    assign full     = count_q[FIFO_DEPTH_LOG2];
    assign usedw    = count_q[FIFO_DEPTH_LOG2-1:0];
    assign do_write = wrreq && !full;
    assign do_read  = rdreq && !empty;
    assign q        = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_write, do_read})
            2'b10:   count_d = count_q + (FIFO_DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
            end
            if (do_read) begin
                rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// Streams a contiguous frame-buffer region over Avalon-MM burst reads into a show-ahead
// FIFO; bursts are only issued when FIFO space is reserved for every returning beat.
module frame_buffer_reader
    import frame_buffer_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned FIFO_DEPTH_LOG2 = 6,
    parameter int unsigned BURST_LENGTH    = DEFAULT_BURST_LENGTH
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        frame_start,
    input  logic [ADDR_WIDTH-1:0]       frame_base,
    input  logic [WORD_COUNT_WIDTH-1:0] frame_words,
    output logic                        busy,
    output logic [7:0]                  error,
    frame_buffer_reader_if.master       bus
);

    localparam int unsigned CntWidth = FIFO_DEPTH_LOG2 + 1;

    reader_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]         next_addr_q, next_addr_d;
    logic [WORD_COUNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [CntWidth-1:0]           outstanding_q, outstanding_d;
    logic                          read_q, read_d;
    logic [ADDR_WIDTH-1:0]         req_addr_q, req_addr_d;
    logic [BURST_COUNT_WIDTH-1:0]  req_len_q, req_len_d;
    logic                          busy_q, busy_d;
    logic [7:0]                    error_q, error_d;

    logic                          fifo_push;
    logic                          fifo_pop;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic [FIFO_DEPTH_LOG2-1:0]    fifo_usedw;
    logic [CntWidth-1:0]           fifo_count;
    logic [DATA_WIDTH-1:0]         fifo_q;
    logic                          beat_expected;

    logic [15:0]                   credit;
    logic [BURST_COUNT_WIDTH-1:0]  len_start;
    logic [BURST_COUNT_WIDTH-1:0]  len_cur;
    logic [BURST_COUNT_WIDTH-1:0]  issue_len;

    // Return path: beats with nothing outstanding are strays and never enter the FIFO.
    assign fifo_count    = {fifo_full, fifo_usedw};
    assign beat_expected = bus.read_readdatavalid && (outstanding_q != '0);
    assign fifo_push     = beat_expected && !fifo_full;
    assign fifo_pop      = !fifo_empty && bus.pixel_ready;

    read_data_fifo #(
        .WIDTH           (DATA_WIDTH),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_read_data_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wrreq   (fifo_push),
        .data    (bus.read_readdata),
        .rdreq   (fifo_pop),
        .q       (fifo_q),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .usedw   (fifo_usedw)
    );

    // Words already buffered plus words still in flight must fit in the FIFO.
    assign credit    = 16'(FIFO_DEPTH) - 16'(fifo_count) - 16'(outstanding_q);
    assign len_start = burst_len(frame_words, BURST_LENGTH);
    assign len_cur   = burst_len(remaining_q, BURST_LENGTH);

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        read_d      = read_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        busy_d      = busy_q;
        error_d     = ERR_NONE;
        issue_len   = '0;

        unique case (state_q)
            StIdle: begin
                // The first credit check is folded into the start cycle so the
                // request appears on the very next cycle.
                if (frame_start && (frame_words != '0)) begin
                    next_addr_d = frame_base;
                    remaining_d = frame_words;
                    busy_d      = 1'b1;
                    if (credit >= 16'(len_start)) begin
                        issue_len  = len_start;
                        read_d     = 1'b1;
                        req_addr_d = frame_base;
                        req_len_d  = len_start;
                        state_d    = StWaitAccept;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (credit >= 16'(len_cur)) begin
                    issue_len  = len_cur;
                    read_d     = 1'b1;
                    req_addr_d = next_addr_q;
                    req_len_d  = len_cur;
                    state_d    = StWaitAccept;
                end
            end
            StWaitAccept: begin
                if (!bus.read_waitrequest) begin
                    read_d      = 1'b0;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(req_len_q);
                    remaining_d = remaining_q - WORD_COUNT_WIDTH'(req_len_q);
                    if (remaining_q == WORD_COUNT_WIDTH'(req_len_q)) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StDrain: begin
                if (outstanding_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (frame_start && busy_q) begin
            error_d = error_d | ERR_START_BUSY;
        end
        if (bus.read_readdatavalid && (outstanding_q == '0)) begin
            error_d = error_d | ERR_STRAY_DATA;
        end
        if (beat_expected && fifo_full) begin
            error_d = error_d | ERR_OVERFLOW;
        end

        // Reserved at issue time, released per returned beat; both may happen together.
        outstanding_d = outstanding_q + CntWidth'(issue_len) - CntWidth'(beat_expected);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            next_addr_q   <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            read_q        <= 1'b0;
            req_addr_q    <= '0;
            req_len_q     <= '0;
            busy_q        <= 1'b0;
            error_q       <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            next_addr_q   <= next_addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            read_q        <= read_d;
            req_addr_q    <= req_addr_d;
            req_len_q     <= req_len_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
        end
    end

    assign bus.read_read       = read_q;
    assign bus.read_address    = req_addr_q;
    assign bus.read_burstcount = req_len_q;
    assign bus.pixel_valid     = !fifo_empty;
    assign bus.pixel_data      = fifo_q;
    assign busy                = busy_q;
    assign error               = error_q;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader: memory model with fixed read latency, burst and
// pixel scoreboards, and an error-code log checked after each scenario.
module tb_frame_buffer_reader;
    import frame_buffer_reader_pkg::*;

    localparam int LAT = 5;

    typedef struct {
        int          t;
        logic [28:0] a;
    } beat_t;

    typedef struct {
        logic [28:0] a;
        logic [7:0]  n;
    } burst_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [28:0] frame_base;
    logic [23:0] frame_words;
    logic        busy;
    logic [7:0]  error;

    frame_buffer_reader_if bus ();

    frame_buffer_reader #(
        .FIFO_DEPTH      (64),
        .FIFO_DEPTH_LOG2 (6),
        .BURST_LENGTH    (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .frame_base  (frame_base),
        .frame_words (frame_words),
        .busy        (busy),
        .error       (error),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_beat_t = 0;
    int          wait_cycles = 0;
    int          in_flight = 0;
    int          max_in_flight = 0;
    int          popped = 0;
    bit          ready_mode = 0;
    bit          inject_stray = 0;
    bit          valid_seen = 0;
    bit          hold_active = 0;
    logic [28:0] hold_a;
    logic [7:0]  hold_n;

    beat_t       beats[$];
    burst_t      exp_burst[$];
    logic [63:0] exp_q[$];
    logic [7:0]  err_log[$];

    function automatic logic [63:0] mem_word(input logic [28:0] a);
        return {a, 6'h2A, ~a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the negedge, then drive inputs just after posedge.
    task automatic cycle();
        burst_t b;
        beat_t  bt;
        int     t;
        @(negedge clock);
        if (error !== 8'h00) err_log.push_back(error);
        if (bus.pixel_valid === 1'b1) valid_seen = 1;
        if (hold_active) begin
            check("hold_read", bus.read_read, 1);
            check("hold_addr", bus.read_address, hold_a);
            check("hold_len", bus.read_burstcount, hold_n);
        end
        hold_active = bus.read_read && bus.read_waitrequest;
        hold_a = bus.read_address;
        hold_n = bus.read_burstcount;
        if (bus.read_read && !bus.read_waitrequest) begin
            check("burst_expected", exp_burst.size() != 0, 1);
            if (exp_burst.size() != 0) begin
                b = exp_burst.pop_front();
                check("burst_addr", bus.read_address, b.a);
                check("burst_len", bus.read_burstcount, b.n);
            end
            for (int i = 0; i < int'(bus.read_burstcount); i++) begin
                t = (cyc + LAT > last_beat_t + 1) ? cyc + LAT : last_beat_t + 1;
                last_beat_t = t;
                bt.t = t;
                bt.a = bus.read_address + 29'(i);
                beats.push_back(bt);
            end
            in_flight += int'(bus.read_burstcount);
            if (in_flight > max_in_flight) max_in_flight = in_flight;
        end
        if (bus.pixel_valid && bus.pixel_ready) begin
            check("pixel_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("pixel_data", bus.pixel_data, exp_q.pop_front());
            popped++;
            in_flight--;
        end
        @(posedge clock);
        cyc++;
        #1;
        frame_start = 1'b0;
        bus.read_waitrequest = (wait_cycles > 0);
        if (bus.read_read && wait_cycles > 0) wait_cycles--;
        if (beats.size() != 0 && beats[0].t <= cyc) begin
            bt = beats.pop_front();
            bus.read_readdatavalid = 1'b1;
            bus.read_readdata = mem_word(bt.a);
        end else if (inject_stray) begin
            inject_stray = 0;
            bus.read_readdatavalid = 1'b1;
            bus.read_readdata = 64'hDEAD_BEEF_0000_0001;
        end else begin
            bus.read_readdatavalid = 1'b0;
            bus.read_readdata = '0;
        end
        bus.pixel_ready = ready_mode;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic start_frame(input logic [28:0] base, input logic [23:0] words,
                               input bit expect_run);
        burst_t      b;
        int          left;
        logic [28:0] a;
        if (expect_run) begin
            for (int i = 0; i < int'(words); i++) exp_q.push_back(mem_word(base + 29'(i)));
            left = int'(words);
            a = base;
            while (left > 0) begin
                b.a = a;
                b.n = 8'((left > 16) ? 16 : left);
                exp_burst.push_back(b);
                a = a + 29'(b.n);
                left -= int'(b.n);
            end
        end
        frame_start = 1'b1;
        frame_base  = base;
        frame_words = words;
        cycle();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0 || beats.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_words_left"}, 64'(exp_q.size()), 0);
        check({tag, "_bursts_left"}, 64'(exp_burst.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"}, bus.read_read, 0);
        check({tag, "_addr"}, bus.read_address, 0);
        check({tag, "_len"}, bus.read_burstcount, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_pvalid"}, bus.pixel_valid, 0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        frame_start = 1'b0;
        frame_base = '0;
        frame_words = '0;
        bus.read_waitrequest = 1'b0;
        bus.read_readdatavalid = 1'b0;
        bus.read_readdata = '0;
        bus.pixel_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        run(3);
        reset_n = 1'b1;
        run(2);

        // Basic frame: three bursts, streamed out in order, no errors.
        ready_mode = 1;
        err_log.delete();
        start_frame(29'h100, 24'd40, 1);
        check("start_latency_read", bus.read_read, 1);
        check("start_latency_addr", bus.read_address, 29'h100);
        check("start_busy", busy, 1);
        wait_idle("basic", 500);
        check("basic_errors", err_log.size(), 0);

        // Consumer stalled: credit must cap requests at the FIFO depth.
        ready_mode = 0;
        max_in_flight = 0;
        start_frame(29'h400, 24'd100, 1);
        run(80);
        check("stall_read_low", bus.read_read, 0);
        check("stall_in_flight", in_flight, 64);
        check("stall_busy", busy, 1);
        check("stall_head_valid", bus.pixel_valid, 1);
        check("stall_head_data", bus.pixel_data, mem_word(29'h400));
        ready_mode = 1;
        wait_idle("stall", 2000);
        check("stall_credit_bound", max_in_flight <= 64, 1);
        check("stall_errors", err_log.size(), 0);

        // Slave stalls the first burst for 7 cycles.
        wait_cycles = 7;
        start_frame(29'h1F0, 24'd20, 1);
        wait_idle("waitreq", 500);
        check("waitreq_errors", err_log.size(), 0);

        // frame_start while busy is rejected; zero-length frame does nothing.
        start_frame(29'h800, 24'd24, 1);
        run(3);
        frame_start = 1'b1;
        frame_base = 29'h900;
        frame_words = 24'd5;
        cycle();
        wait_idle("busy_start", 500);
        check("busy_err_count", err_log.size(), 1);
        check("busy_err_code", (err_log.size() > 0) ? err_log[0] : 8'h00, ERR_START_BUSY);
        err_log.delete();
        start_frame(29'h500, 24'd0, 1);
        check("zero_busy_now", busy, 0);
        check("zero_read_now", bus.read_read, 0);
        run(8);
        check("zero_busy_later", busy, 0);
        check("zero_errors", err_log.size(), 0);

        // Stray beat while idle.
        err_log.delete();
        valid_seen = 0;
        inject_stray = 1;
        run(6);
        check("stray_err_count", err_log.size(), 1);
        check("stray_err_code", (err_log.size() > 0) ? err_log[0] : 8'h00, ERR_STRAY_DATA);
        check("stray_no_pixel", valid_seen, 0);

        // Reset mid-burst, then a clean frame.
        err_log.delete();
        popped = 0;
        start_frame(29'h2000, 24'd16, 1);
        n = 0;
        while (popped < 3 && n < 100) begin
            cycle();
            n++;
        end
        check("midreset_popped", popped, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        beats.delete();
        exp_q.delete();
        exp_burst.delete();
        hold_active = 0;
        in_flight = 0;
        last_beat_t = cyc;
        bus.read_readdatavalid = 1'b0;
        run(3);
        reset_n = 1'b1;
        run(2);
        start_frame(29'h3000, 24'd20, 1);
        wait_idle("after_reset", 500);
        check("after_reset_errors", err_log.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
